cp0_timer_bank: RTL and testbench



---
 rtl/cp0_timer_bank.sv | 88 ++++++++
 tb/tb_cp0_timer_bank.sv | 192 +++++++++++++++++++
 2 files changed

// File: rtl/cp0_timer_bank.sv
// cp0_timer_bank: prescaled free-running Count with NUM_CMP armed Compare channels and sticky pending interrupts
//   clk, rst            clock, asynchronous active-high reset
//   cp0_write_*         register write strobe, addr, sel, data (Count = 9/0, Compare k = 11/k)
//   cp0_read_*          register read addr, sel; cp0_read_data is combinational with write bypass
//   freeze              holds Count and prescaler
//   count_o             current Count
//   irq_pending         per-channel sticky pending bits
//   timer_irq           OR of irq_pending
module cp0_timer_bank #(
    parameter int NUM_CMP = 2,
    parameter int CNT_W = 32,
    parameter int DIV = 2
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               cp0_write_en,
    input  logic [4:0]         cp0_write_addr,
    input  logic [2:0]         cp0_write_sel,
    input  logic [CNT_W-1:0]   cp0_write_data,
    input  logic [4:0]         cp0_read_addr,
    input  logic [2:0]         cp0_read_sel,
    output logic [CNT_W-1:0]   cp0_read_data,
    input  logic               freeze,
    output logic [CNT_W-1:0]   count_o,
    output logic [NUM_CMP-1:0] irq_pending,
    output logic               timer_irq
);
    localparam int DW = DIV > 1 ? $clog2(DIV) : 1;
    logic [DW-1:0] div_cnt;
    logic [CNT_W-1:0] count, count_inc;
    logic [CNT_W-1:0] cmp [NUM_CMP];
    logic [NUM_CMP-1:0] pending, cmp_rd;
    logic cnt_we, cnt_rd, byp, tick, inc;
    assign cnt_we = cp0_write_en && cp0_write_addr == 5'd9 && cp0_write_sel == 3'd0;
    assign cnt_rd = cp0_read_addr == 5'd9 && cp0_read_sel == 3'd0;
    assign byp = cp0_write_en && cp0_write_addr == cp0_read_addr && cp0_write_sel == cp0_read_sel;
    // With DIV = 1 div_cnt is pinned at 0, so tick is simply !freeze.
    assign tick = !freeze && div_cnt == DW'(DIV - 1);
    // A Count write suppresses the increment and therefore any match on that edge.
    assign inc = tick && !cnt_we;
    assign count_inc = count + CNT_W'(1);
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            count <= '0;
            div_cnt <= '0;
        end else if (cnt_we) begin
            count <= cp0_write_data;
            div_cnt <= '0;
        end else if (!freeze) begin
            count <= tick ? count_inc : count;
            div_cnt <= tick ? '0 : div_cnt + DW'(1);
        end
    end
    genvar k;
    generate
        for (k = 0; k < NUM_CMP; k++) begin : g_ch
            logic we, armed, pend;
            logic [CNT_W-1:0] val;
            assign we = cp0_write_en && cp0_write_addr == 5'd11 && cp0_write_sel == 3'(k);
            assign cmp_rd[k] = cp0_read_addr == 5'd11 && cp0_read_sel == 3'(k);
            assign cmp[k] = val;
            assign pending[k] = pend;
            // The write clear takes priority over a match on the same edge.
            always_ff @(posedge clk or posedge rst) begin
                if (rst) begin
                    val <= '0;
                    armed <= 1'b0;
                    pend <= 1'b0;
                end else if (we) begin
                    val <= cp0_write_data;
                    armed <= 1'b1;
                    pend <= 1'b0;
                end else if (inc && armed && val == count_inc) begin
                    pend <= 1'b1;
                end
            end
        end
    endgenerate
    always_comb begin
        cp0_read_data = '0;
        if (cnt_rd) cp0_read_data = byp ? cp0_write_data : count;
        for (int i = 0; i < NUM_CMP; i++)
            if (cmp_rd[i]) cp0_read_data = byp ? cp0_write_data : cmp[i];
    end
    assign count_o = count;
    assign irq_pending = pending;
    assign timer_irq = |pending;
endmodule

// File: tb/tb_cp0_timer_bank.sv
// tb_cp0_timer_bank: directed vector table plus reset sequence for cp0_timer_bank (NUM_CMP=3, CNT_W=16, DIV=2)
module tb_cp0_timer_bank;
    logic clk = 1'b0;
    logic rst;
    logic cp0_write_en;
    logic [4:0] cp0_write_addr, cp0_read_addr;
    logic [2:0] cp0_write_sel, cp0_read_sel;
    logic [15:0] cp0_write_data, cp0_read_data, count_o;
    logic freeze;
    logic [2:0] irq_pending;
    logic timer_irq;
    int total = 0;
    int passed = 0;

    cp0_timer_bank #(.NUM_CMP(3), .CNT_W(16), .DIV(2)) dut (
        .clk(clk), .rst(rst),
        .cp0_write_en(cp0_write_en), .cp0_write_addr(cp0_write_addr),
        .cp0_write_sel(cp0_write_sel), .cp0_write_data(cp0_write_data),
        .cp0_read_addr(cp0_read_addr), .cp0_read_sel(cp0_read_sel),
        .cp0_read_data(cp0_read_data), .freeze(freeze), .count_o(count_o),
        .irq_pending(irq_pending), .timer_irq(timer_irq)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic we;
        logic [4:0] wa;
        logic [2:0] ws;
        logic [15:0] wd;
        logic [4:0] ra;
        logic [2:0] rs;
        logic frz;
        logic [15:0] erd;
        logic [15:0] ecnt;
        logic [2:0] ep;
    } vec_t;
    vec_t v[$];

    task automatic add(input logic we, input logic [4:0] wa, input logic [2:0] ws, input logic [15:0] wd,
                       input logic [4:0] ra, input logic [2:0] rs, input logic frz,
                       input logic [15:0] erd, input logic [15:0] ecnt, input logic [2:0] ep);
        vec_t r;
        r.we = we; r.wa = wa; r.ws = ws; r.wd = wd; r.ra = ra; r.rs = rs;
        r.frz = frz; r.erd = erd; r.ecnt = ecnt; r.ep = ep;
        v.push_back(r);
    endtask

    task automatic idle(input logic frz, input logic [15:0] erd, input logic [15:0] ecnt, input logic [2:0] ep);
        add(0, 0, 0, 0, 9, 0, frz, erd, ecnt, ep);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, expected %h", name, act, exp);
        else passed++;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic we, input logic [4:0] wa, input logic [2:0] ws, input logic [15:0] wd,
                         input logic [4:0] ra, input logic [2:0] rs, input logic frz);
        cp0_write_en = we; cp0_write_addr = wa; cp0_write_sel = ws; cp0_write_data = wd;
        cp0_read_addr = ra; cp0_read_sel = rs; freeze = frz;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, expected completion");
        $fatal(1);
    end

    initial begin
        rst = 1'b1;
        drive(0, 0, 0, 0, 9, 0, 0);
        // count_o after each edge steps 0,0,1,1,... with DIV=2
        idle(0, 16'h0000, 16'h0000, 3'b000);
        idle(0, 16'h0000, 16'h0001, 3'b000);
        idle(0, 16'h0001, 16'h0001, 3'b000);
        idle(0, 16'h0001, 16'h0002, 3'b000);
        add(1, 11, 0, 16'h0005, 11, 0, 0, 16'h0005, 16'h0002, 3'b000);
        add(0, 0, 0, 0, 11, 0, 0, 16'h0005, 16'h0003, 3'b000);
        idle(0, 16'h0003, 16'h0003, 3'b000);
        idle(0, 16'h0003, 16'h0004, 3'b000);
        idle(0, 16'h0004, 16'h0004, 3'b000);
        idle(0, 16'h0004, 16'h0005, 3'b001);
        idle(0, 16'h0005, 16'h0005, 3'b001);
        add(1, 11, 0, 16'h0009, 11, 0, 0, 16'h0009, 16'h0006, 3'b000);
        idle(0, 16'h0006, 16'h0006, 3'b000);
        idle(0, 16'h0006, 16'h0007, 3'b000);
        idle(0, 16'h0007, 16'h0007, 3'b000);
        idle(0, 16'h0007, 16'h0008, 3'b000);
        idle(0, 16'h0008, 16'h0008, 3'b000);
        idle(0, 16'h0008, 16'h0009, 3'b001);
        // rearm at 10; second write lands on the match edge and must win
        add(1, 11, 0, 16'h000A, 11, 0, 0, 16'h000A, 16'h0009, 3'b000);
        add(1, 11, 0, 16'h000A, 9, 0, 0, 16'h0009, 16'h000A, 3'b000);
        idle(0, 16'h000A, 16'h000A, 3'b000);
        // Count write while increment due
        add(1, 9, 0, 16'h0007, 9, 0, 0, 16'h0007, 16'h0007, 3'b000);
        idle(0, 16'h0007, 16'h0007, 3'b000);
        idle(0, 16'h0007, 16'h0008, 3'b000);
        add(1, 11, 1, 16'h1234, 11, 1, 0, 16'h1234, 16'h0008, 3'b000);
        add(0, 0, 0, 0, 11, 3, 0, 16'h0000, 16'h0009, 3'b000);
        add(1, 4, 0, 16'hAAAA, 4, 0, 0, 16'h0000, 16'h0009, 3'b000);
        add(1, 11, 3, 16'h0055, 11, 3, 0, 16'h0000, 16'h000A, 3'b001);
        // freeze for 10 cycles with a Count write in the middle
        for (int i = 0; i < 4; i++) idle(1, 16'h000A, 16'h000A, 3'b001);
        add(1, 9, 0, 16'h0040, 9, 0, 1, 16'h0040, 16'h0040, 3'b001);
        for (int i = 0; i < 5; i++) idle(1, 16'h0040, 16'h0040, 3'b001);
        idle(0, 16'h0040, 16'h0040, 3'b001);
        idle(0, 16'h0040, 16'h0041, 3'b001);
        // wrap through 0 with channel 2 unarmed
        add(1, 11, 0, 16'h0100, 11, 0, 0, 16'h0100, 16'h0041, 3'b000);
        add(1, 9, 0, 16'hFFFE, 9, 0, 0, 16'hFFFE, 16'hFFFE, 3'b000);
        idle(0, 16'hFFFE, 16'hFFFE, 3'b000);
        idle(0, 16'hFFFE, 16'hFFFF, 3'b000);
        idle(0, 16'hFFFF, 16'hFFFF, 3'b000);
        idle(0, 16'hFFFF, 16'h0000, 3'b000);
        add(1, 11, 1, 16'h0000, 11, 1, 0, 16'h0000, 16'h0000, 3'b000);
        add(1, 9, 0, 16'hFFFF, 9, 0, 0, 16'hFFFF, 16'hFFFF, 3'b000);
        idle(0, 16'hFFFF, 16'hFFFF, 3'b000);
        idle(0, 16'hFFFF, 16'h0000, 3'b010);
        add(0, 0, 0, 0, 11, 2, 0, 16'h0000, 16'h0000, 3'b010);

        tick();
        chk("reset count", count_o, 16'h0000);
        chk("reset pending", irq_pending, 3'b000);
        chk("reset timer_irq", timer_irq, 1'b0);
        chk("reset read count", cp0_read_data, 16'h0000);
        rst = 1'b0;

        foreach (v[i]) begin
            drive(v[i].we, v[i].wa, v[i].ws, v[i].wd, v[i].ra, v[i].rs, v[i].frz);
            #1;
            chk($sformatf("row%0d read", i), cp0_read_data, v[i].erd);
            tick();
            chk($sformatf("row%0d count", i), count_o, v[i].ecnt);
            chk($sformatf("row%0d pending", i), irq_pending, v[i].ep);
            chk($sformatf("row%0d timer_irq", i), timer_irq, |v[i].ep);
        end

        // asynchronous reset mid-cycle with pending[1] set and count 0x33
        drive(1, 9, 0, 16'h0033, 9, 0, 0);
        tick();
        drive(0, 0, 0, 0, 9, 0, 0);
        chk("pre-reset count", count_o, 16'h0033);
        chk("pre-reset pending", irq_pending, 3'b010);
        #2;
        rst = 1'b1;
        #1;
        chk("async count", count_o, 16'h0000);
        chk("async pending", irq_pending, 3'b000);
        chk("async timer_irq", timer_irq, 1'b0);
        drive(0, 0, 0, 0, 11, 0, 0);
        #1;
        chk("reset read 11/0", cp0_read_data, 16'h0000);
        drive(0, 0, 0, 0, 4, 0, 0);
        #1;
        chk("reset read 4/0", cp0_read_data, 16'h0000);
        drive(0, 0, 0, 0, 9, 0, 0);
        tick();
        chk("held reset count", count_o, 16'h0000);
        #2;
        rst = 1'b0;
        tick();
        chk("restart e1", count_o, 16'h0000);
        tick();
        chk("restart e2", count_o, 16'h0001);
        tick();
        chk("restart e3", count_o, 16'h0001);
        tick();
        chk("restart e4", count_o, 16'h0002);
        // old Compare values are gone and channels unarmed: crossing 0 sets nothing
        drive(1, 9, 0, 16'hFFFF, 9, 0, 0);
        tick();
        drive(0, 0, 0, 0, 9, 0, 0);
        tick();
        tick();
        chk("post-reset wrap count", count_o, 16'h0000);
        chk("post-reset wrap pending", irq_pending, 3'b000);
        tick();
        tick();
        chk("post-reset later pending", irq_pending, 3'b000);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
